// File: rtl/bopit_pkg.sv
// Shared Bop-it game types: round FSM encoding and round counter sizing.
package bopit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  localparam int                     ROUND_CNT_W   = 8;
  localparam logic [ROUND_CNT_W-1:0] ROUND_CNT_MAX = 8'd255;

endpackage

// File: rtl/tick_edge_detect.sv
// Two-flop sampler plus rising-edge detect: one-cycle tick_out per rising edge of level_in.
// Latency: tick_out is high in the cycle after the 1st clk edge that samples the new level.
module tick_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level_in,
  output logic tick_out
);

  logic tick_s;
  logic tick_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_s <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      tick_s <= level_in;
      tick_q <= tick_s;
    end
  end

  assign tick_out = tick_s & ~tick_q;

endmodule

// File: rtl/round_timer.sv
// Bop-it round timer: counts down the response window in divided-clock ticks, reports pass/timeout/miss.
// All outputs registered; optional ROUND_TIMER_PAUSE_EN adds a pause input that freezes a running round.
module round_timer
  import bopit_pkg::*;
#(
  parameter int WINDOW_W    = 5,
  parameter int INIT_WINDOW = 20,
  parameter int MIN_WINDOW  = 4,
  parameter int STEP        = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick_clk_in,
  input  logic                   start,
  input  logic                   hit,
  input  logic                   miss,
`ifdef ROUND_TIMER_PAUSE_EN
  input  logic                   pause,
`endif
  output logic                   busy,
  output logic                   pass,
  output logic                   timeout,
  output logic                   game_over,
  output logic [WINDOW_W-1:0]    remaining,
  output logic [WINDOW_W-1:0]    window,
  output logic [ROUND_CNT_W-1:0] round_cnt
);

  localparam logic [WINDOW_W-1:0] INIT_W = WINDOW_W'(INIT_WINDOW);
  localparam logic [WINDOW_W-1:0] ONE_W  = WINDOW_W'(1);
  localparam logic [WINDOW_W:0]   MIN_X  = (WINDOW_W+1)'(MIN_WINDOW);
  localparam logic [WINDOW_W:0]   STEP_X = (WINDOW_W+1)'(STEP);

  state_t                   state;
  state_t                   state_nxt;
  logic                     tick;
  logic                     paused;
  logic                     timeout_nxt;
  logic [WINDOW_W-1:0]      rem_nxt;
  logic [WINDOW_W-1:0]      win_nxt;
  logic [WINDOW_W-1:0]      win_shrunk;
  logic [WINDOW_W:0]        win_dec;
  logic [ROUND_CNT_W-1:0]   rcnt_nxt;

  tick_edge_detect u_tick (
    .clk      (clk),
    .reset    (reset),
    .level_in (tick_clk_in),
    .tick_out (tick)
  );

`ifdef ROUND_TIMER_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  // Extra top bit catches window < STEP, which would otherwise wrap to a huge window.
  assign win_dec    = {1'b0, window} - STEP_X;
  assign win_shrunk = (win_dec[WINDOW_W] || (win_dec < MIN_X)) ? MIN_X[WINDOW_W-1:0]
                                                               : win_dec[WINDOW_W-1:0];

  always_comb begin
    state_nxt   = state;
    timeout_nxt = 1'b0;
    rem_nxt     = remaining;
    win_nxt     = window;
    rcnt_nxt    = round_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          rem_nxt   = window;
        end
      end
      RUN: begin
        if (!paused) begin
          if (hit) begin
            state_nxt = PASS;
          end else if (miss) begin
            state_nxt = FAIL;
          end else if (tick) begin
            if (remaining == ONE_W) begin
              state_nxt   = FAIL;
              timeout_nxt = 1'b1;
              rem_nxt     = '0;
            end else begin
              rem_nxt = remaining - ONE_W;
            end
          end
        end
      end
      PASS: begin
        state_nxt = IDLE;
        win_nxt   = win_shrunk;
        if (round_cnt != ROUND_CNT_MAX) rcnt_nxt = round_cnt + 8'd1;
      end
      FAIL: begin
        if (start) begin
          state_nxt = RUN;
          win_nxt   = INIT_W;
          rcnt_nxt  = '0;
          rem_nxt   = INIT_W;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      game_over <= 1'b0;
      remaining <= '0;
      window    <= INIT_W;
      round_cnt <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt == RUN);
      pass      <= (state_nxt == PASS);
      timeout   <= timeout_nxt;
      game_over <= (state_nxt == FAIL);
      remaining <= rem_nxt;
      window    <= win_nxt;
      round_cnt <= rcnt_nxt;
    end
  end

endmodule
